// File: rtl/sd_mux2_pkg.sv
// Shared definitions for the sd_enmux2 / sd_join2 narrow link.
// Both ends use the same bit-ordering helpers so they stay bit-consistent.
package sd_mux2_pkg;

    localparam int unsigned MaxWidth = 64;
    localparam int unsigned MaxHalf  = MaxWidth / 2;

    typedef enum logic {
        s_first  = 1'b0,
        s_second = 1'b1
    } phase_t;

    // Full token from two halves: first half on odd bits, second on even bits.
    // Halves are zero-extended to MaxHalf; only the low 'half' bits are used.
    function automatic logic [MaxWidth-1:0] interleave2(input logic [MaxHalf-1:0] f,
                                                        input logic [MaxHalf-1:0] s,
                                                        input int unsigned half);
        logic [MaxWidth-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxHalf; i++) begin
            if (i < half) begin
                r[2*i+1] = f[i];
                r[2*i]   = s[i];
            end
        end
        return r;
    endfunction

    // Inverse of interleave2: odd bits to the first half, even bits to the second.
    function automatic void deinterleave2(input  logic [MaxWidth-1:0] d,
                                          input  int unsigned         half,
                                          output logic [MaxHalf-1:0]  f,
                                          output logic [MaxHalf-1:0]  s);
        f = '0;
        s = '0;
        for (int unsigned i = 0; i < MaxHalf; i++) begin
            if (i < half) begin
                f[i] = d[2*i+1];
                s[i] = d[2*i];
            end
        end
    endfunction

endpackage

// File: rtl/sd_join2.sv
// Srdy/drdy 2:1 de-multiplexer: pairs two half-width tokens into one full-width token.
// c_drdy depends on registered state only, breaking the loop with the upstream enmux.
module sd_join2
    import sd_mux2_pkg::*;
#(
    parameter int unsigned width    = 8,
    parameter int unsigned adj_bits = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_srdy,
    output logic               c_drdy,
    input  logic [width/2-1:0] c_data,
    output logic               p_srdy,
    input  logic               p_drdy,
    output logic [width-1:0]   p_data,
    output logic               partial
);

    localparam int unsigned Half = width / 2;

    phase_t             phase, phase_d;
    logic               p_srdy_d;
    logic [Half-1:0]    hold_r, hold_d;
    logic [width-1:0]   p_data_d;

    always_comb begin
        phase_d  = phase;
        p_srdy_d = p_srdy;
        hold_d   = hold_r;
        p_data_d = p_data;
        c_drdy   = (phase == s_first) | ~p_srdy;

        if (p_srdy && p_drdy) begin
            p_srdy_d = 1'b0;
        end

        case (phase)
            s_first: begin
                // First half may land while the output register still drains.
                if (c_srdy) begin
                    hold_d  = c_data;
                    phase_d = s_second;
                end
            end
            s_second: begin
                if (c_srdy && c_drdy) begin
                    if (adj_bits == 0) begin
                        p_data_d = {hold_r, c_data};
                    end else begin
                        p_data_d = width'(interleave2(MaxHalf'(hold_r), MaxHalf'(c_data), Half));
                    end
                    p_srdy_d = 1'b1;
                    phase_d  = s_first;
                end
            end
            default: phase_d = s_first;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= s_first;
            p_srdy <= 1'b0;
        end else begin
            phase  <= phase_d;
            p_srdy <= p_srdy_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_r <= hold_d;
        p_data <= p_data_d;
    end

    assign partial = (phase == s_second);

endmodule

// File: tb/tb_sd_join2.sv
// Bench for sd_join2: two instances (8-bit MSB-first, 16-bit interleaved) checked every
// cycle against a token-level model, plus directed literal expectations.
module tb_sd_join2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0] csrdy, pdrdy;
    logic [7:0] cd [2];

    logic       a_c_drdy, a_p_srdy, a_partial;
    logic [3:0] a_c_data;
    logic [7:0] a_p_data;
    logic       b_c_drdy, b_p_srdy, b_partial;
    logic [7:0] b_c_data;
    logic [15:0] b_p_data;

    assign a_c_data = cd[0][3:0];
    assign b_c_data = cd[1];

    sd_join2 #(.width(8), .adj_bits(0)) dut_a (
        .clk(clk), .reset(reset),
        .c_srdy(csrdy[0]), .c_drdy(a_c_drdy), .c_data(a_c_data),
        .p_srdy(a_p_srdy), .p_drdy(pdrdy[0]), .p_data(a_p_data),
        .partial(a_partial)
    );

    sd_join2 #(.width(16), .adj_bits(1)) dut_b (
        .clk(clk), .reset(reset),
        .c_srdy(csrdy[1]), .c_drdy(b_c_drdy), .c_data(b_c_data),
        .p_srdy(b_p_srdy), .p_drdy(pdrdy[1]), .p_data(b_p_data),
        .partial(b_partial)
    );

    logic [1:0]  cdrdy_dut, psrdy_dut, partial_dut;
    logic [15:0] pdata_dut [2];
    assign cdrdy_dut   = {b_c_drdy, a_c_drdy};
    assign psrdy_dut   = {b_p_srdy, a_p_srdy};
    assign partial_dut = {b_partial, a_partial};
    assign pdata_dut[0] = {8'h00, a_p_data};
    assign pdata_dut[1] = b_p_data;

    // Token-level model: pending first half and one-deep output slot per instance.
    int          pend [2];
    int          full [2];
    logic [7:0]  hold_m [2];
    logic [15:0] out_m [2];

    int n_chk = 0;
    int n_pass = 0;
    bit thr_win = 1'b0;
    int thr_hs = 0;
    int thr_cd = 0;

    function automatic logic [15:0] assemble_m(int d, logic [7:0] f, logic [7:0] s);
        logic [15:0] r;
        r = '0;
        if (d == 0) begin
            r = 16'(f[3:0]) * 16 + 16'(s[3:0]);
        end else begin
            for (int i = 0; i < 8; i++) begin
                r[2*i+1] = f[i];
                r[2*i]   = s[i];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                pend[d] = 0;
                full[d] = 0;
            end else begin
                bit ready, acc;
                ready = (pend[d] == 0) || (full[d] == 0);
                acc   = csrdy[d] && ready;
                if (full[d] != 0 && pdrdy[d]) full[d] = 0;
                if (acc) begin
                    if (pend[d] == 0) begin
                        hold_m[d] = cd[d];
                        pend[d]   = 1;
                    end else begin
                        out_m[d] = assemble_m(d, hold_m[d], cd[d]);
                        full[d]  = 1;
                        pend[d]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("c_drdy[%0d]", d), 16'(cdrdy_dut[d]),
                  16'((pend[d] == 0) || (full[d] == 0)));
            check($sformatf("partial[%0d]", d), 16'(partial_dut[d]), 16'(pend[d] == 1));
            check($sformatf("p_srdy[%0d]", d), 16'(psrdy_dut[d]), 16'(full[d] == 1));
            if (full[d] == 1)
                check($sformatf("p_data[%0d]", d), pdata_dut[d], out_m[d]);
        end
        if (thr_win) begin
            if (b_p_srdy && pdrdy[1]) thr_hs++;
            if (b_c_drdy) thr_cd++;
        end
    endtask

    task automatic cycle(input bit chk = 1'b1);
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk) check_all();
    endtask

    task automatic drive(input int d, input logic s, input logic [7:0] data, input logic pr);
        csrdy[d] = s;
        cd[d]    = data;
        pdrdy[d] = pr;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 8'h0, 1'b1);
        drive(1, 1'b0, 8'h0, 1'b1);
        cycle(1'b0);
        cycle(1'b1);
        reset = 1'b0;

        // Basic (A) and interleave (B)
        drive(0, 1'b1, 8'h0A, 1'b1);
        drive(1, 1'b1, 8'hFF, 1'b1);
        cycle();
        check("a_partial_after_first", 16'(a_partial), 16'h1);
        drive(0, 1'b1, 8'h05, 1'b1);
        drive(1, 1'b1, 8'h00, 1'b1);
        cycle();
        check("a_basic_srdy", 16'(a_p_srdy), 16'h1);
        check("a_basic_data", 16'(a_p_data), 16'h00A5);
        check("b_interleave_aaaa", b_p_data, 16'hAAAA);
        drive(0, 1'b0, 8'h00, 1'b1);
        drive(1, 1'b1, 8'h00, 1'b1);
        cycle();
        drive(1, 1'b1, 8'hFF, 1'b1);
        cycle();
        check("b_interleave_5555", b_p_data, 16'h5555);
        drive(1, 1'b0, 8'h00, 1'b1);

        // Reset mid-token on A
        drive(0, 1'b1, 8'h07, 1'b1);
        cycle();
        check("a_partial_before_reset", 16'(a_partial), 16'h1);
        reset = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b1);
        cycle();
        reset = 1'b0;
        check("a_partial_after_reset", 16'(a_partial), 16'h0);
        check("a_srdy_after_reset", 16'(a_p_srdy), 16'h0);
        drive(0, 1'b1, 8'h03, 1'b1);
        cycle();
        drive(0, 1'b1, 8'h0C, 1'b1);
        cycle();
        check("a_reset_recover_data", 16'(a_p_data), 16'h003C);
        drive(0, 1'b0, 8'h00, 1'b1);
        cycle();

        // Backpressure on A: six stalled cycles with the link saturated
        drive(0, 1'b1, 8'h01, 1'b0);
        cycle();
        drive(0, 1'b1, 8'h02, 1'b0);
        cycle();
        drive(0, 1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        check("bp_c_drdy_low", 16'(a_c_drdy), 16'h0);
        check("bp_partial", 16'(a_partial), 16'h1);
        check("bp_srdy", 16'(a_p_srdy), 16'h1);
        check("bp_data_held", 16'(a_p_data), 16'h0012);
        drive(0, 1'b1, 8'h04, 1'b1);
        cycle();
        cycle();
        check("bp_next_token", 16'(a_p_data), 16'h0034);
        drive(0, 1'b0, 8'h00, 1'b1);
        cycle();

        // Throughput on B
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        thr_win = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1'b1, 8'($urandom), 1'b1);
            cycle();
        end
        thr_win = 1'b0;
        check("thr_handshakes", 16'(thr_hs), 16'd10);
        check("thr_c_drdy_cycles", 16'(thr_cd), 16'd20);

        // Randomized traffic on both instances
        for (int i = 0; i < 3000; i++) begin
            for (int d = 0; d < 2; d++) begin
                drive(d, 1'(($urandom % 4) != 0), 8'($urandom),
                      1'(($urandom % 8) < ((i / 500) % 2 == 0 ? 6 : 2)));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sd_join2.md
# sd_join2

Srdy/drdy 2:1 data de-multiplexer: collects two consecutive half-width tokens and reassembles them into one full-width token. It is the receive end of the `sd_enmux2` narrow link. It sits downstream of the half-width channel, typically behind an `sd_input` or `sd_iohalf` stage. It drives a full-width srdy/drdy producer interface.

## Interface

Parameters:
- `width`, default 8. Full token width; must be even. Input halves are `width/2`.
- `adj_bits`, default 1. Bit ordering on the link.
  - 1: first half carries odd bits, second half carries even bits.
  - 0: first half carries the MSB half, second half carries the LSB half.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `c_srdy`  in  1  half-token valid
- `c_drdy`  out  1  half-token accept
- `c_data`  in  width/2  half-token data
- `p_srdy`  out  1  full-token valid
- `p_drdy`  in  1  full-token accept
- `p_data`  out  width  full-token data
- `partial`  out  1  first half held, second half pending (status only)

## Operation

- Phase register has two states:
  - `s_first`: awaiting the first half.
  - `s_second`: first half held in `hold_r`, awaiting the second half.
- Output register holds `p_data` plus the valid flag `p_srdy`.
- `c_drdy` is a function of registered state only. There is no combinational path from `c_srdy` or `p_drdy` to `c_drdy`. This breaks the loop with the enmux, whose `c_drdy` depends on its `p_drdy`.
  - `s_first`: `c_drdy = 1`.
  - `s_second`: `c_drdy = !p_srdy`.
- Transitions:
  - `s_first`, `c_srdy`: `hold_r <= c_data`, go to `s_second`.
  - `s_second`, `c_srdy & c_drdy`: `p_data <= assemble(hold_r, c_data)`, `p_srdy <= 1`, go to `s_first`.
  - `s_second`, otherwise: stay; `hold_r` is unchanged.
- `p_srdy` clears on `p_srdy & p_drdy`. A load and a drain can never occur in the same cycle, because a load requires `p_srdy = 0`.
- A first half may be accepted while the output register is still full. This allows the next token's first half to overlap the drain.
- Assembly, with F = first half and S = second half:
  - `adj_bits = 0`: `p_data = {F, S}`.
  - `adj_bits = 1`: `p_data[2i+1] = F[i]` and `p_data[2i] = S[i]`, for i in 0..width/2-1.
- `partial = (phase == s_second)`.
- Illegal phase encoding goes to `s_first`.

## Timing

- Reset values:
  - phase = `s_first`
  - `p_srdy` = 0
  - `partial` = 0
  - `c_drdy` = 1 in the cycle after reset
- `hold_r` and `p_data` are not reset; `p_data` is don't-care while `p_srdy = 0`.
- Latency: second half accepted in cycle t → `p_srdy = 1` with valid `p_data` in cycle t+1.
- Throughput: one full token per 2 cycles, sustained with `p_drdy` held high (matches the link rate).
  - Token N second half at t.
  - Output drained at t+1.
  - Token N+1 first half at t+1, second half at t+2.
- Backpressure: with `p_drdy` low, at most one full token plus one first half are buffered; `c_drdy` then stays 0 until the drain.
- `p_data` is stable while `p_srdy & !p_drdy`.
- Reset mid-token: a held first half is discarded and the next accepted half is treated as a first half. The paired enmux must be reset in the same cycle.

## Structure

- Shared package `sd_mux2_pkg` contains:
  - phase enum `{s_first, s_second}`;
  - functions `interleave2` / `deinterleave2` (parameterised by width), reused by `sd_enmux2` so both ends stay bit-consistent.
- No sub-module. Single always_comb for next-state and assembly, plus two always_ff blocks (control with reset, data without reset).

## Test plan

- Basic, `width=8`, `adj_bits=0`: halves 0xA then 0x5 with `p_drdy=1` → `p_data=0xA5`, `p_srdy` high one cycle after the second half is accepted.
- Interleave, `width=8`, `adj_bits=1`: halves 0xF then 0x0 → `p_data=0xAA`; halves 0x0 then 0xF → 0x55.
- Backpressure: `p_drdy=0` for 6 cycles while the link is saturated.
  - First half of the next token is accepted; `c_drdy=0` in `s_second`; `p_data` holds.
  - Release → tokens delivered in order, none lost or duplicated.
- Loopback: `sd_enmux2` → `sd_join2` for `width=16`, both `adj_bits` values, 1000 random tokens, random `c_srdy` and `p_drdy` → output equals input.
- Reset mid-token: assert reset while `partial=1` → `partial=0` and `p_srdy=0` next cycle; next halves 0x3, 0xC (`adj_bits=0`) → 0x3C.
- Throughput: continuous tokens with `p_drdy=1` → one `p_srdy & p_drdy` every 2 cycles, no bubbles.
